// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath: produces the HI/LO pair for one
// operation and flags a zero divisor.
module md_compute
    import md_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  md_op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        divisor;
    logic [31:0]        quo;
    logic [31:0]        rem;

    // Signed division works on magnitudes so 0x80000000 / -1 wraps to
    // 0x80000000 with a zero remainder instead of trapping.
    always_comb begin
        a_ext    = {{32{A[31]}}, A};
        b_ext    = {{32{B[31]}}, B};
        prod_s   = a_ext * b_ext;
        prod_u   = {32'd0, A} * {32'd0, B};
        a_neg    = (md_op == MD_DIV) && A[31];
        b_neg    = (md_op == MD_DIV) && B[31];
        mag_a    = a_neg ? (32'd0 - A) : A;
        mag_b    = b_neg ? (32'd0 - B) : B;
        div_zero = (md_op[1] == 1'b1) && (B == 32'd0);
        divisor  = (B == 32'd0) ? 32'd1 : mag_b;
        quo      = mag_a / divisor;
        rem      = mag_a % divisor;
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        case (md_op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_lo = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
                res_hi = a_neg ? (32'd0 - rem) : rem;
            end
            default: begin
                res_lo = quo;
                res_hi = rem;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | accepts start or MTHI/MTLO; start wins over the writes
// MD_RUN  | counting down fixed latency; result commits when cnt == 0
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    md_state_t          state;
    md_state_t          state_next;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_ok;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               div_zero;
    logic               launch;
    logic               commit;

    md_compute u_compute (
        .A        (A),
        .B        (B),
        .md_op    (md_op),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign busy = (state == MD_RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus launch/commit strobes for the datapath.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        commit     = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = MD_RUN;
                end
            end
            MD_RUN: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = MD_IDLE;
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    // Counter, pending result and architectural HI/LO; a zero divisor
    // leaves pend_ok low so the commit edge changes nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_ok <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (launch) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_ok <= ~div_zero;
            cnt     <= md_op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end else if (commit) begin
            if (pend_ok) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (state == MD_RUN) begin
            cnt <= cnt - 1'b1;
        end else begin
            if (hi_we) hi <= A;
            if (lo_we) lo <= A;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_md_unit;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain 64-bit integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     q;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT:  ref_op = sa * sb;
            MD_MULTU: ref_op = ua * ub;
            MD_DIV: begin
                q = sa / sb;
                r = sa % sb;
                ref_op = {r[31:0], q[31:0]};
            end
            default: begin
                q = ua / ub;
                r = ua % ub;
                ref_op = {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Behavioural model: remaining busy cycles and a pending result.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pok;
    int          m_rem = 0;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        logic [63:0] r;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_rem = 0; m_pok = 0; m_valid = 1'b1;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0 && m_pok) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start) begin
            m_rem = md_op[1] ? DC : MC;
            m_pok = !(md_op[1] && B == 0);
            if (m_pok) begin
                r = ref_op(md_op, A, B);
                m_phi = r[63:32];
                m_plo = r[31:0];
            end
        end else begin
            if (hi_we) m_hi = A;
            if (lo_we) m_lo = A;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_busy", {63'd0, busy}, {63'd0, (m_rem > 0)});
            check("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
            check("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; hi_we = 0; lo_we = 0; reset = 0;
    endtask

    // Launch one op and count busy cycles, bounded.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_n, input string name);
        int n;
        start = 1; md_op = op; A = a; B = b;
        tick();
        start = 0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check(name, n, exp_n);
    endtask

    initial begin
        int n;
        logic [63:0] r;
        reset = 1; start = 0; md_op = 0; A = 0; B = 0; hi_we = 0; lo_we = 0;
        tick();
        reset = 0;
        check("reset_busy", {63'd0, busy}, 0);
        check("reset_hi", {32'd0, hi}, 0);
        check("reset_lo", {32'd0, lo}, 0);

        // Model pins against hand-computed values.
        r = ref_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        check("model_div_ovf", r, 64'h00000000_80000000);
        r = ref_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
        check("model_div_neg", r, 64'hFFFFFFFF_FFFFFFFD);

        // 1
        do_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, MC, "t1_busy");
        check("t1_hi", {32'd0, hi}, 64'h1);
        check("t1_lo", {32'd0, lo}, 64'hFFFFFFFE);
        // 2
        do_op(MD_MULT, 32'hFFFFFFFD, 32'd7, MC, "t2m_busy");
        check("t2m_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, DC, "t2d_busy");
        check("t2d_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        // 3
        do_op(MD_DIVU, 32'd7, 32'd2, DC, "t3u_busy");
        check("t3u_hilo", {hi, lo}, 64'h00000001_00000003);
        do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, DC, "t3o_busy");
        check("t3o_hilo", {hi, lo}, 64'h00000000_80000000);
        do_op(MD_DIV, 32'd5, 32'd0, DC, "t3z_busy");
        check("t3z_hilo", {hi, lo}, 64'h00000000_80000000);

        // 4: inputs during RUN are ignored
        start = 1; md_op = MD_MULT; A = 32'd6; B = 32'd7;
        tick();
        start = 0;
        n = 1;
        tick(); n++;
        hi_we = 1; start = 1; md_op = MD_DIV; A = 32'h1234; B = 32'd3;
        tick(); n++;
        hi_we = 0; start = 0;
        check("t4_hold", {hi, lo}, 64'h00000000_80000000);
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("t4_busy", n, MC + 1);
        check("t4_hilo", {hi, lo}, 64'h00000000_0000002A);
        check("t4_idle", {63'd0, busy}, 0);

        // 5: MTHI in idle, then start beating MTLO
        hi_we = 1; A = 32'hAAAA5555;
        tick();
        hi_we = 0;
        check("t5_mthi", {hi, lo}, 64'hAAAA5555_0000002A);
        start = 1; lo_we = 1; md_op = MD_MULTU; A = 32'd3; B = 32'd4;
        tick();
        start = 0; lo_we = 0;
        check("t5_drop", {32'd0, lo}, 64'h2A);
        check("t5_run", {63'd0, busy}, 1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("t5_hilo", {hi, lo}, 64'h00000000_0000000C);

        // 6: reset mid-DIV discards the pending result
        start = 1; md_op = MD_DIV; A = 32'd100; B = 32'd7;
        tick();
        start = 0;
        tick(); tick();
        reset = 1;
        tick();
        reset = 0;
        check("t6_busy", {63'd0, busy}, 0);
        check("t6_hilo", {hi, lo}, 0);
        repeat (15) tick();
        check("t6_nocommit", {hi, lo}, 0);

        // Randomized phase, checked by the per-cycle compare process.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            hi_we = ($urandom_range(0, 3) == 0);
            lo_we = ($urandom_range(0, 3) == 0);
            md_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: A = $urandom;
                1: A = 32'($urandom_range(0, 20));
                2: A = 32'h80000000;
                default: A = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
            endcase
            case ($urandom_range(0, 4))
                0: B = $urandom;
                1: B = 32'($urandom_range(1, 20));
                2: B = 32'd0;
                3: B = 32'hFFFFFFFF;
                default: B = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
            endcase
            tick();
        end
        idle_inputs();
        repeat (DC + 2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from EX, models a fixed iterative latency, and asserts busy so the hazard unit stalls later HI/LO users. It serves MFHI/MFLO reads from the hi and lo outputs.

Parameters:
MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (minimum 1)
DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (minimum 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  launch operation md_op on A and B this cycle
md_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
A  input  32  rs operand; also the MTHI/MTLO data
B  input  32  rt operand
hi_we  input  1  MTHI: write A into HI
lo_we  input  1  MTLO: write A into LO
busy  output  1  operation in flight
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: one clock with reset=1 gives busy=0, hi=0, lo=0, state IDLE, counter 0. Reset overrides every other input, including in mid-operation; any pending result is discarded.
- State machine has two states:
  - IDLE. When start is sampled at edge k, the block:
    - computes the result from A, B, md_op combinationally and latches it into pend_hi/pend_lo;
    - loads the counter with N-1, where N = MULT_CYCLES or DIV_CYCLES;
    - moves to RUN.
  - RUN. The counter decrements each edge. At the edge where the counter is 0, pend_hi and pend_lo commit to HI and LO and the state returns to IDLE.
- busy equals (state == RUN). For start at edge k, busy is 1 after edges k..k+N-1, which is exactly N cycles. The new hi/lo are visible and busy is 0 after edge k+N.
- Priority in IDLE: start beats hi_we/lo_we. If both arrive in the same cycle, the MTHI/MTLO write is dropped. hi_we and lo_we together write A into both registers.
- In RUN, start, hi_we and lo_we are ignored. The hazard unit guarantees they are not issued; the bench checks that they are ignored.
- hi and lo hold their old values throughout RUN and are never partially updated.
- Arithmetic:
  - MULT: signed 32x32 to 64 bits; HI is [63:32], LO is [31:0].
  - MULTU: the same, unsigned.
  - DIV: signed. LO is the quotient, truncated toward zero. HI is the remainder, with the sign of the dividend.
  - DIVU: unsigned. LO is the quotient, HI is the remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero (B=0) still runs the full DIV_CYCLES busy period. HI and LO keep their prior values and nothing is committed.
- Back-to-back operations: a start in the cycle immediately after busy falls is accepted normally.

Decomposition:
- Shared package md_pkg holds:
  - MD_MULT, MD_MULTU, MD_DIV, MD_DIVU op encodings (2-bit);
  - default MULT_CYCLES/DIV_CYCLES constants;
  - state encodings MD_IDLE, MD_RUN.
- One combinational sub-module, md_compute, takes A, B and md_op. It outputs res_hi, res_lo and div_zero, and handles the sign and overflow rules. md_unit contains only the FSM, counter, pending registers and HI/LO.

Test Plan:
1. Reset, then MULTU A=0xFFFFFFFF B=2 -> busy high exactly 5 cycles; afterwards hi=0x00000001, lo=0xFFFFFFFE.
2. MULT A=0xFFFFFFFD (-3) B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV A=0xFFFFFFF9 (-7) B=2 -> busy exactly 10 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFD.
3. Overflow and zero divisor:
   - DIVU A=7 B=2 -> hi=1, lo=3.
   - DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000, hi=0.
   - Then DIV A=5 B=0 -> busy 10 cycles; hi/lo unchanged.
4. During a MULT, pulse hi_we with A=0x1234 and start with DIV -> both ignored. hi/lo hold old values until commit, then show the MULT result. busy returns to 0 after exactly 5 cycles.
5. In IDLE:
   - hi_we=1 with A=0xAAAA5555 -> hi=0xAAAA5555 next cycle, lo unchanged.
   - start=1 and lo_we=1 in the same cycle -> the MTLO write is dropped and the operation runs.
6. Assert reset for one cycle when a DIV is 3 cycles in -> busy=0, hi=0, lo=0 next cycle, and no later commit occurs.
